irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Sequential interrupt arbiter: the registered successor to the combinational 8-to-3 priority encoders. It latches rising edges on `NUM_SRC` interrupt lines into a pending register and applies a per-source mask. It selects one source by fixed or round-robin priority and presents it to the CPU core through a valid/ack handshake, holding it in service until end-of-interrupt. It sits between peripheral IRQ lines and the ARM7 core's IRQ entry logic.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources; legal range 2..32, power of two not required.
- `ID_W`, default `$clog2(NUM_SRC)`: width of the source index.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `irq_in` input `NUM_SRC`: raw interrupt lines, edge-sensitive (rising edge = event).
- `mask` input `NUM_SRC`: 1 blocks selection of that source; pending is still recorded.
- `rr_mode` input 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- `irq_valid` output 1: a selected source is offered to the core.
- `irq_id` output `ID_W`: index of the offered or in-service source.
- `irq_ack` input 1: core accepts the offer; sampled only while `irq_valid`=1.
- `in_service` output 1: accepted interrupt awaiting end-of-interrupt.
- `eoi` input 1: end-of-interrupt; sampled only while `in_service`=1.
- `pending` output `NUM_SRC`: current pending register.

## Operation
- Edge detect: `irq_q` is the registered copy of `irq_in`. An event on source i is `irq_in[i] & ~irq_q[i]`.
- Pending update: the event sets `pend[i]`. An accepted ack on source i clears `pend[i]`. If an event and an ack clear hit the same bit in the same cycle, the set wins and `pend[i]` stays 1.
- Eligibility: `elig = pend & ~mask`.
- Fixed mode: the winner is the highest set index of `elig`.
- Round-robin mode: the search starts at `rr_ptr` and proceeds upward, wrapping from `NUM_SRC-1` to 0. The winner is the first set bit found.
- On each accepted ack, `rr_ptr` is loaded with (winner + 1) mod `NUM_SRC`, in either mode.
- State machine, three states:
  - IDLE: if `|elig`, register the winner into `irq_id` and go to OFFER; otherwise stay.
  - OFFER: `irq_valid`=1 and `irq_id` is frozen. Later changes to `mask` or `pend` do not withdraw or alter the offer. On `irq_ack`, clear the pending bit, update `rr_ptr` and go to SERVICE.
  - SERVICE: `in_service`=1 and `irq_id` is held. On `eoi`, go to IDLE.
- Ignored inputs: `irq_ack` outside OFFER and `eoi` outside SERVICE have no effect.
- No nesting: while in SERVICE, new events only accumulate in `pend`.
- Reset values:
  - `pend`, `irq_q` and `rr_ptr` are 0; state is IDLE.
  - `irq_valid`, `in_service` and `irq_id` are 0.
  - A line held high through reset counts as an edge on the first post-reset cycle, because `irq_q` resets to 0.
- Reset mid-operation: an offer or service in progress is discarded and all pending events are lost.

## Timing
- Event-to-offer latency: if `irq_in[i]` is sampled 1 at edge k and was 0 at edge k-1, then `pend[i]`=1 after edge k and `irq_valid`=1 after edge k+1.
- Handshake:
  - `irq_ack` high at edge m during OFFER: `irq_valid`=0 and `in_service`=1 after edge m.
  - `eoi` at edge n: IDLE after edge n, and the next offer after edge n+1.
- Minimum spacing between consecutive offers is 3 cycles: offer, service, idle.
- `irq_id` changes only on the IDLE→OFFER transition or on reset.

## Configuration
- `IRQ_ARB_ROUND_ROBIN_EN` defined: round-robin search and the `rr_ptr` register are built, and `rr_mode` selects the policy.
- `IRQ_ARB_ROUND_ROBIN_EN` undefined: only fixed priority is built, `rr_mode` is ignored and `rr_ptr` is absent.
- All other behaviour is identical in both builds.

## Structure
- Package `irq_arb_pkg` holds:
  - the state encoding as localparams `ST_IDLE`=2'd0, `ST_OFFER`=2'd1, `ST_SERVICE`=2'd2;
  - `MAX_SRC`=32 for parameter checking.
- Sub-module `irq_select` is purely combinational. Inputs: `elig`, `rr_ptr`, `rr_mode`. Outputs: `winner` and `any`. It is instantiated once.
- The top level holds the edge detect, the pending register, `rr_ptr` and the state machine.

## Test plan
- Reset, then pulse `irq_in[3]` for 1 cycle → `pending`=0x08 one cycle later and `irq_valid`=1 with `irq_id`=3 one cycle after that. Ack → `pending`=0x00 and `in_service`=1. Eoi → IDLE.
- Fixed mode, events on sources 1, 5 and 6 in the same cycle → offers in order 6, 5, 1, each completed with ack and eoi.
- Round-robin mode, sources 2 and 6 re-pulsed after every service → granted ids alternate 2, 6, 2, 6. With `NUM_SRC`=6 and sources 5 and 0 both active, the search wraps and grants 5 then 0.
- Mask bit 4 while source 4 pulses → no offer and `pending[4]`=1. Clear the mask → offer id 4 on the next IDLE evaluation. Set the mask during OFFER → offer still stands.
- Pulse source 2 in the same cycle that `irq_ack` accepts id 2 → `pending[2]` remains 1 and a second offer of id 2 follows the eoi.
- Assert `rst` during SERVICE with pending 0x30 → all outputs 0 and `pending`=0x00 after the reset edge. `irq_in` held high across reset → offer 2 cycles after reset release.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared definitions for the interrupt arbiter.
//   MAX_SRC  - upper bound on the number of interrupt sources
//   state_e  - arbiter state encoding (IDLE / OFFER / SERVICE)
package irq_arb_pkg;

  localparam int unsigned MAX_SRC = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_select.sv
// irq_select: combinational winner selection over the eligible sources.
//   elig    in  [NUM_SRC] - pending & ~mask
//   rr_ptr  in  [ID_W]    - round-robin search start index
//   rr_mode in            - 0 = fixed (highest index wins), 1 = round-robin
//   winner  out [ID_W]    - selected source index (0 when none eligible)
//   any     out           - at least one source eligible
// Build option: IRQ_ARB_ROUND_ROBIN_EN enables the round-robin search;
// otherwise only fixed priority is built and rr_ptr/rr_mode are ignored.
module irq_select
  import irq_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               rr_mode,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W-1:0] fix_w;

  // Fixed priority: last set bit in an ascending scan is the highest index.
  always_comb begin
    fix_w = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) fix_w = ID_W'(i);
    end
  end

  assign any = |elig;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] hi_w;
  logic [ID_W-1:0] lo_w;
  logic            hi_found;
  logic            lo_found;

  // Wrapping search from rr_ptr: the lowest set bit at or above the pointer
  // wins; if none, the search has wrapped and the lowest set bit overall wins.
  always_comb begin
    hi_w     = '0;
    lo_w     = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && !lo_found) begin
        lo_w     = ID_W'(i);
        lo_found = 1'b1;
      end
      if (elig[i] && !hi_found && (i >= 32'(rr_ptr))) begin
        hi_w     = ID_W'(i);
        hi_found = 1'b1;
      end
    end
  end

  assign winner = !rr_mode ? fix_w : (hi_found ? hi_w : lo_w);
`else
  logic unused_rr;
  assign unused_rr = ^{rr_ptr, rr_mode};
  assign winner    = fix_w;
`endif

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: registered interrupt arbiter with valid/ack/eoi handshake.
// Latches rising edges of irq_in into a pending register, selects one
// unmasked source (fixed or round-robin priority) and holds it through
// OFFER (irq_valid) and SERVICE (in_service) until end-of-interrupt.
//   clk, rst    in            - clock, synchronous active-high reset
//   irq_in      in  [NUM_SRC] - raw interrupt lines (rising edge = event)
//   mask        in  [NUM_SRC] - 1 blocks selection; pending still recorded
//   rr_mode     in            - 0 = fixed priority, 1 = round-robin
//   irq_valid   out           - offer to the core
//   irq_id      out [ID_W]    - offered / in-service source index
//   irq_ack     in            - core accepts offer (OFFER only)
//   in_service  out           - accepted interrupt awaiting eoi
//   eoi         in            - end-of-interrupt (SERVICE only)
//   pending     out [NUM_SRC] - pending register
// Build option: IRQ_ARB_ROUND_ROBIN_EN builds rr_ptr and the round-robin
// policy; without it rr_mode is ignored and only fixed priority exists.
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               rr_mode,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic               in_service,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] pending
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
    $error("irq_arbiter: NUM_SRC must be in 2..%0d", MAX_SRC);
  end

  state_e               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic [NUM_SRC-1:0]   irq_q;
  logic [NUM_SRC-1:0]   events;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   clr;
  logic                 ack_acc;
  logic [ID_W-1:0]      sel_winner;
  logic                 sel_any;
  logic [ID_W-1:0]      sel_ptr;
  logic                 sel_mode;

  assign events  = irq_in & ~irq_q;
  assign elig    = pend_q & ~mask;
  assign ack_acc = (state_q == ST_OFFER) && irq_ack;

  // Set has priority over the ack clear on the same bit.
  always_comb begin
    clr = '0;
    if (ack_acc) clr[id_q] = 1'b1;
    pend_d = (pend_q & ~clr) | events;
  end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ack_acc) begin
      rr_ptr_d = (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign sel_ptr  = rr_ptr_q;
  assign sel_mode = rr_mode;
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;
  assign sel_ptr        = '0;
  assign sel_mode       = 1'b0;
`endif

  irq_select #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_select (
    .elig    (elig),
    .rr_ptr  (sel_ptr),
    .rr_mode (sel_mode),
    .winner  (sel_winner),
    .any     (sel_any)
  );

  // irq_id is captured only on IDLE->OFFER, so the offer stays frozen.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          id_d    = sel_winner;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (irq_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      irq_q   <= irq_in;
    end
  end

  assign irq_valid  = (state_q == ST_OFFER);
  assign in_service = (state_q == ST_SERVICE);
  assign irq_id     = id_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed self-checking bench for irq_arbiter.
// Drives an 8-source instance and a 6-source instance (wrap-around case).
// Expectations for the round-robin scenario depend on IRQ_ARB_ROUND_ROBIN_EN.
module tb_irq_arbiter;

  logic       clk;
  logic       rst;
  logic       rr_mode;

  logic [7:0] irq_in, mask, pending;
  logic       irq_valid, irq_ack, in_service, eoi;
  logic [2:0] irq_id;

  logic [5:0] irq_in6, mask6, pend6;
  logic       valid6, ack6, insvc6, eoi6;
  logic [2:0] id6;

  int n_cmp;
  int n_bad;

  logic [2:0] exp_seq [4];

  irq_arbiter #(.NUM_SRC(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask       (mask),
    .rr_mode    (rr_mode),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .in_service (in_service),
    .eoi        (eoi),
    .pending    (pending)
  );

  irq_arbiter #(.NUM_SRC(6)) u_dut6 (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in6),
    .mask       (mask6),
    .rr_mode    (rr_mode),
    .irq_valid  (valid6),
    .irq_id     (id6),
    .irq_ack    (ack6),
    .in_service (insvc6),
    .eoi        (eoi6),
    .pending    (pend6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    rr_mode = 1'b0;
    irq_in  = '0; mask  = '0; irq_ack = 1'b0; eoi  = 1'b0;
    irq_in6 = '0; mask6 = '0; ack6    = 1'b0; eoi6 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (irq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", irq_valid); end
    n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL reset_insvc got=%0b exp=0", in_service); end
    n_cmp++; if (irq_id !== 3'd0) begin n_bad++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending got=%h exp=00", pending); end
    n_cmp++; if (pend6 !== 6'h00 || valid6 !== 1'b0) begin n_bad++; $display("FAIL reset_dut6 got pend=%h valid=%0b exp 00/0", pend6, valid6); end
  endtask

  task automatic test_basic();
    do_reset();
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL basic_pend got=%h exp=08", pending); end
    n_cmp++; if (irq_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%0b exp=0", irq_valid); end
    tick();
    n_cmp++; if (irq_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%0b exp=1", irq_valid); end
    n_cmp++; if (irq_id !== 3'd3) begin n_bad++; $display("FAIL basic_id got=%0d exp=3", irq_id); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL basic_ack_pend got=%h exp=00", pending); end
    n_cmp++; if (in_service !== 1'b1 || irq_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack_state got insvc=%0b valid=%0b exp 1/0", in_service, irq_valid); end
    n_cmp++; if (irq_id !== 3'd3) begin n_bad++; $display("FAIL basic_svc_id got=%0d exp=3", irq_id); end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    n_cmp++; if (in_service !== 1'b0 || irq_valid !== 1'b0) begin n_bad++; $display("FAIL basic_eoi got insvc=%0b valid=%0b exp 0/0", in_service, irq_valid); end
    // Stray ack while idle with nothing pending must do nothing.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n_cmp++; if (in_service !== 1'b0 || irq_valid !== 1'b0) begin n_bad++; $display("FAIL basic_stray_ack got insvc=%0b valid=%0b exp 0/0", in_service, irq_valid); end
  endtask

  task automatic test_fixed();
    do_reset();
    exp_seq[0] = 3'd6; exp_seq[1] = 3'd5; exp_seq[2] = 3'd1;
    irq_in = 8'h62;
    tick();
    irq_in = 8'h00;
    n_cmp++; if (pending !== 8'h62) begin n_bad++; $display("FAIL fixed_pend got=%h exp=62", pending); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (irq_valid !== 1'b1 || irq_id !== exp_seq[i]) begin n_bad++; $display("FAIL fixed_offer%0d got valid=%0b id=%0d exp 1/%0d", i, irq_valid, irq_id, exp_seq[i]); end
      if (i == 0) begin
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd6) begin n_bad++; $display("FAIL fixed_eoi_in_offer got valid=%0b id=%0d exp 1/6", irq_valid, irq_id); end
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      n_cmp++; if (in_service !== 1'b1) begin n_bad++; $display("FAIL fixed_svc%0d got=%0b exp=1", i, in_service); end
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
    end
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL fixed_drained got=%h exp=00", pending); end
  endtask

  task automatic test_round_robin();
    do_reset();
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 3'd2; exp_seq[1] = 3'd6; exp_seq[2] = 3'd2; exp_seq[3] = 3'd6;
`else
    exp_seq[0] = 3'd6; exp_seq[1] = 3'd6; exp_seq[2] = 3'd6; exp_seq[3] = 3'd6;
`endif
    rr_mode = 1'b1;
    irq_in  = 8'h44;
    tick();
    irq_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (irq_valid !== 1'b1 || irq_id !== exp_seq[i]) begin n_bad++; $display("FAIL rr_grant%0d got valid=%0b id=%0d exp 1/%0d", i, irq_valid, irq_id, exp_seq[i]); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      eoi = 1'b1;
      if (i < 3) irq_in[exp_seq[i]] = 1'b1;
      tick();
      eoi    = 1'b0;
      irq_in = 8'h00;
    end
    rr_mode = 1'b0;
  endtask

  task automatic test_wrap6();
    do_reset();
    rr_mode = 1'b1;
    irq_in6 = 6'h10;
    tick();
    irq_in6 = 6'h00;
    tick();
    n_cmp++; if (valid6 !== 1'b1 || id6 !== 3'd4) begin n_bad++; $display("FAIL wrap_first got valid=%0b id=%0d exp 1/4", valid6, id6); end
    ack6 = 1'b1;
    tick();
    ack6 = 1'b0;
    eoi6    = 1'b1;
    irq_in6 = 6'h21;
    tick();
    eoi6    = 1'b0;
    irq_in6 = 6'h00;
    n_cmp++; if (pend6 !== 6'h21) begin n_bad++; $display("FAIL wrap_pend got=%h exp=21", pend6); end
    tick();
    n_cmp++; if (valid6 !== 1'b1 || id6 !== 3'd5) begin n_bad++; $display("FAIL wrap_g5 got valid=%0b id=%0d exp 1/5", valid6, id6); end
    ack6 = 1'b1; tick(); ack6 = 1'b0;
    eoi6 = 1'b1; tick(); eoi6 = 1'b0;
    tick();
    n_cmp++; if (valid6 !== 1'b1 || id6 !== 3'd0) begin n_bad++; $display("FAIL wrap_g0 got valid=%0b id=%0d exp 1/0", valid6, id6); end
    ack6 = 1'b1; tick(); ack6 = 1'b0;
    eoi6 = 1'b1; tick(); eoi6 = 1'b0;
    n_cmp++; if (pend6 !== 6'h00) begin n_bad++; $display("FAIL wrap_drained got=%h exp=00", pend6); end
    rr_mode = 1'b0;
  endtask

  task automatic test_mask();
    do_reset();
    mask   = 8'h10;
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    n_cmp++; if (irq_valid !== 1'b0) begin n_bad++; $display("FAIL mask_blocked got=%0b exp=0", irq_valid); end
    n_cmp++; if (pending !== 8'h10) begin n_bad++; $display("FAIL mask_pend got=%h exp=10", pending); end
    mask = 8'h00;
    tick();
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin n_bad++; $display("FAIL mask_unblock got valid=%0b id=%0d exp 1/4", irq_valid, irq_id); end
    // Masking the offered source and raising a higher one must not disturb the offer.
    mask   = 8'h10;
    irq_in = 8'h80;
    tick();
    irq_in = 8'h00;
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin n_bad++; $display("FAIL mask_offer_held got valid=%0b id=%0d exp 1/4", irq_valid, irq_id); end
    n_cmp++; if (pending !== 8'h90) begin n_bad++; $display("FAIL mask_offer_pend got=%h exp=90", pending); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (in_service !== 1'b1 || pending !== 8'h80) begin n_bad++; $display("FAIL mask_ack got insvc=%0b pend=%h exp 1/80", in_service, pending); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    mask = 8'h00;
    tick();
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin n_bad++; $display("FAIL mask_next got valid=%0b id=%0d exp 1/7", irq_valid, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL mask_drained got=%h exp=00", pending); end
  endtask

  task automatic test_set_wins();
    do_reset();
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin n_bad++; $display("FAIL setwin_offer got valid=%0b id=%0d exp 1/2", irq_valid, irq_id); end
    irq_ack = 1'b1;
    irq_in  = 8'h04;
    tick();
    irq_ack = 1'b0;
    irq_in  = 8'h00;
    n_cmp++; if (in_service !== 1'b1 || pending !== 8'h04) begin n_bad++; $display("FAIL setwin_pend got insvc=%0b pend=%h exp 1/04", in_service, pending); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin n_bad++; $display("FAIL setwin_reoffer got valid=%0b id=%0d exp 1/2", irq_valid, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL setwin_drained got=%h exp=00", pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq_in = 8'hB0;
    tick();
    irq_in = 8'h00;
    tick();
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin n_bad++; $display("FAIL rmid_offer got valid=%0b id=%0d exp 1/7", irq_valid, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (in_service !== 1'b1 || pending !== 8'h30) begin n_bad++; $display("FAIL rmid_svc got insvc=%0b pend=%h exp 1/30", in_service, pending); end
    rst    = 1'b1;
    irq_in = 8'h02;
    tick();
    n_cmp++; if (irq_valid !== 1'b0 || in_service !== 1'b0) begin n_bad++; $display("FAIL rmid_outs got valid=%0b insvc=%0b exp 0/0", irq_valid, in_service); end
    n_cmp++; if (irq_id !== 3'd0 || pending !== 8'h00) begin n_bad++; $display("FAIL rmid_clear got id=%0d pend=%h exp 0/00", irq_id, pending); end
    rst = 1'b0;
    tick();
    n_cmp++; if (pending !== 8'h02 || irq_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_held_edge got pend=%h valid=%0b exp 02/0", pending, irq_valid); end
    tick();
    n_cmp++; if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin n_bad++; $display("FAIL rmid_held_offer got valid=%0b id=%0d exp 1/1", irq_valid, irq_id); end
    irq_in = 8'h00;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    rr_mode = 1'b0;
    irq_in  = '0; mask  = '0; irq_ack = 1'b0; eoi  = 1'b0;
    irq_in6 = '0; mask6 = '0; ack6    = 1'b0; eoi6 = 1'b0;
    test_reset();
    test_basic();
    test_fixed();
    test_round_robin();
    test_wrap6();
    test_mask();
    test_set_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
